// File: rtl/robsmult_n.sv
// -----------------------------------------------------------------------------
// robsmult_n
// Sequential Robertson multiplier, one multiplier bit per clock, with a
// start/done handshake and a per-operation signed/unsigned mode.
// Signed operations run add-shift steps for the low WIDTH-1 bits.
// The sign bit is then handled by a final subtract-shift step.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   start        request a multiply; only sampled while busy=0
//   signed_mode  1 = two's complement operands, 0 = unsigned (captured on start)
//   multiplier   operand X (captured on start)
//   multiplicand operand Y (captured on start)
//   busy         high while iterating / correcting
//   done         one-cycle pulse when product becomes valid
//   product      2*WIDTH-bit result, held until the next completion
// -----------------------------------------------------------------------------
module robsmult_n #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ITER    = 2'd1;
    localparam logic [1:0] CORRECT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]         state_r;
    logic [WIDTH-1:0]   y_r;
    logic [WIDTH:0]     a_r;
    logic [WIDTH-1:0]   q_r;
    logic               f_r;
    logic [CW-1:0]      cnt_r;
    logic               mode_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH+1:0]   a_wide_s;
    logic [WIDTH+1:0]   y_wide_s;
    logic [WIDTH+1:0]   sum_s;
    logic               f_upd_s;
    logic               ext_s;
    logic [WIDTH:0]     a_shift_s;
    logic [WIDTH-1:0]   q_shift_s;
    logic               accept_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

    // A new operation is accepted from IDLE or in the DONE cycle (back-to-back)
    assign accept_s = start & ((state_r == IDLE) | (state_r == DONE));

    // Add/subtract-and-shift datapath for one multiplier bit
    always_comb begin
        a_wide_s  = {(WIDTH+2){1'b0}};
        y_wide_s  = {(WIDTH+2){1'b0}};
        sum_s     = {(WIDTH+2){1'b0}};
        f_upd_s   = f_r;
        ext_s     = 1'b0;
        a_shift_s = {(WIDTH+1){1'b0}};
        q_shift_s = {WIDTH{1'b0}};

        // Extra top bit lets the unsigned carry-out be observed directly
        if (mode_r) begin
            a_wide_s = {a_r[WIDTH], a_r};
            y_wide_s = {{2{y_r[WIDTH-1]}}, y_r};
        end else begin
            a_wide_s = {1'b0, a_r};
            y_wide_s = {2'b00, y_r};
        end

        if (q_r[0]) begin
            if ((state_r == CORRECT) && mode_r) begin
                sum_s = a_wide_s - y_wide_s;
            end else begin
                sum_s = a_wide_s + y_wide_s;
            end
            f_upd_s = f_r | (mode_r & y_r[WIDTH-1]);
        end else begin
            sum_s   = a_wide_s;
            f_upd_s = f_r;
        end

        // During ITER the signed partial product is negative exactly when a
        // negative Y has been added at least once, which is what F records.
        // The correction subtract can flip the sign, so it uses S's sign bit.
        if (mode_r) begin
            if (state_r == CORRECT) begin
                ext_s = sum_s[WIDTH];
            end else begin
                ext_s = f_upd_s;
            end
        end else begin
            ext_s = sum_s[WIDTH+1];
        end

        a_shift_s = {ext_s, sum_s[WIDTH:1]};
        q_shift_s = {sum_s[0], q_r[WIDTH-1:1]};
    end

    // Control FSM, operand capture, iteration registers and product register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            y_r       <= {WIDTH{1'b0}};
            a_r       <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            f_r       <= 1'b0;
            cnt_r     <= {CW{1'b0}};
            mode_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        y_r     <= multiplicand;
                        q_r     <= multiplier;
                        a_r     <= {(WIDTH+1){1'b0}};
                        f_r     <= 1'b0;
                        mode_r  <= signed_mode;
                        cnt_r   <= CW'(WIDTH - 2);
                        state_r <= ITER;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ITER: begin
                    a_r    <= a_shift_s;
                    q_r    <= q_shift_s;
                    f_r    <= f_upd_s;
                    busy_r <= 1'b1;
                    done_r <= 1'b0;
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= CORRECT;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                CORRECT: begin
                    a_r       <= a_shift_s;
                    q_r       <= q_shift_s;
                    f_r       <= f_upd_s;
                    product_r <= {a_shift_s[WIDTH-1:0], q_shift_s};
                    state_r   <= DONE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_robsmult_n.sv
// -----------------------------------------------------------------------------
// tb_robsmult_n
// Self-checking bench for robsmult_n at WIDTH=8 and WIDTH=16. Expected
// products come from directed constants or from an arithmetic reference
// model (plain signed/unsigned integer multiplication).
// -----------------------------------------------------------------------------
module tb_robsmult_n;

    logic        clk = 1'b0;
    logic        reset8 = 1'b1;
    logic        start8 = 1'b0;
    logic        mode8 = 1'b0;
    logic [7:0]  mult8 = 8'h00;
    logic [7:0]  mcand8 = 8'h00;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;

    logic        reset16 = 1'b1;
    logic        start16 = 1'b0;
    logic        mode16 = 1'b0;
    logic [15:0] mult16 = 16'h0000;
    logic [15:0] mcand16 = 16'h0000;
    logic        busy16;
    logic        done16;
    logic [31:0] prod16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    robsmult_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset8), .start(start8), .signed_mode(mode8),
        .multiplier(mult8), .multiplicand(mcand8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    robsmult_n #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset16), .start(start16), .signed_mode(mode16),
        .multiplier(mult16), .multiplicand(mcand16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    // Reference: interpret operands per mode and multiply as integers
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                            input logic [15:0] y, input bit m);
        longint xv, yv, pv, mask;
        xv = longint'(x);
        yv = longint'(y);
        if (m && x[w-1]) xv = xv - (longint'(1) << w);
        if (m && y[w-1]) yv = yv - (longint'(1) << w);
        pv = xv * yv;
        mask = (longint'(1) << (2 * w)) - longint'(1);
        return 32'(pv & mask);
    endfunction

    // Drive one 8-bit operation; returns at the negedge of the done cycle
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input bit m,
                       input bit now, input bit disturb,
                       output logic [15:0] p, output int lat, output int bcyc);
        if (!now) @(negedge clk);
        mult8 = x; mcand8 = y; mode8 = m; start8 = 1'b1;
        @(posedge clk);
        lat = 0; bcyc = 0;
        @(negedge clk);
        start8 = 1'b0;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) bcyc++;
            if (disturb) begin
                if (lat == 0) begin mult8 = ~x; mcand8 = y + 8'd1; mode8 = ~m; end
                if (lat == 2) begin start8 = 1'b1; mult8 = 8'h11; mcand8 = 8'h22; end
                if (lat == 4) start8 = 1'b0;
            end
            @(posedge clk); lat++; @(negedge clk);
        end
        start8 = 1'b0;
        p = prod8;
    endtask

    // Drive one 16-bit operation; returns at the negedge of the done cycle
    task automatic op16(input logic [15:0] x, input logic [15:0] y, input bit m,
                        input bit now, output logic [31:0] p, output int lat);
        if (!now) @(negedge clk);
        mult16 = x; mcand16 = y; mode16 = m; start16 = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        start16 = 1'b0;
        while (done16 !== 1'b1 && lat < 60) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        p = prod16;
    endtask

    task automatic test_reset();
        reset8 = 1'b1; reset16 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        checks++; if (prod8 !== 16'h0000) begin failures++; $display("FAIL reset_prod8 got=%h exp=0000", prod8); end
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL reset_busy16 got=%b exp=0", busy16); end
        checks++; if (prod16 !== 32'h0) begin failures++; $display("FAIL reset_prod16 got=%h exp=0", prod16); end
        reset8 = 1'b0; reset16 = 1'b0;
    endtask

    task automatic test_signed_basic();
        logic [15:0] p; int lat, bc;
        op8(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0, p, lat, bc);
        checks++; if (p !== 16'hFFF1) begin failures++; $display("FAIL basic_prod got=%h exp=FFF1", p); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=8", bc); end
        repeat (3) @(negedge clk);
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done8); end
        checks++; if (prod8 !== 16'hFFF1) begin failures++; $display("FAIL prod_hold got=%h exp=FFF1", prod8); end
    endtask

    task automatic test_corners();
        logic [7:0]  xs [5] = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'h80};
        logic [7:0]  ys [5] = '{8'h80, 8'h7F, 8'hFF, 8'hFF, 8'h02};
        bit          ms [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] es [5] = '{16'h4000, 16'hC080, 16'hFF81, 16'hFE01, 16'h0100};
        logic [15:0] p; int lat, bc;
        for (int i = 0; i < 5; i++) begin
            op8(xs[i], ys[i], ms[i], 1'b0, 1'b0, p, lat, bc);
            checks++;
            if (p !== es[i]) begin
                failures++;
                $display("FAIL corner%0d x=%h y=%h m=%0d got=%h exp=%h", i, xs[i], ys[i], ms[i], p, es[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] p; int lat, bc;
        op8(8'h7F, 8'hFF, 1'b1, 1'b0, 1'b1, p, lat, bc);
        checks++; if (p !== 16'hFF81) begin failures++; $display("FAIL ignore_start_prod got=%h exp=FF81", p); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL ignore_start_latency got=%0d exp=8", lat); end
        repeat (3) @(negedge clk);
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL ignore_start_no_queue got=%b exp=0", busy8); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] p; int lat, bc;
        op8(8'hFD, 8'h05, 1'b1, 1'b0, 1'b0, p, lat, bc);
        op8(8'h02, 8'h03, 1'b1, 1'b1, 1'b0, p, lat, bc);
        checks++; if (p !== 16'h0006) begin failures++; $display("FAIL b2b_prod got=%h exp=0006", p); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p; int lat, bc;
        @(negedge clk);
        mult8 = 8'h5A; mcand8 = 8'hC3; mode8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset8 = 1'b1;
        @(negedge clk);
        reset8 = 1'b0;
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done8); end
        checks++; if (prod8 !== 16'h0000) begin failures++; $display("FAIL midreset_prod got=%h exp=0000", prod8); end
        op8(8'hE7, 8'h19, 1'b1, 1'b0, 1'b0, p, lat, bc);
        checks++;
        if (p !== ref_mul(8, {8'h00, 8'hE7}, {8'h00, 8'h19}, 1'b1) & 32'hFFFF) begin
            failures++; $display("FAIL midreset_fresh got=%h exp=%h", p, ref_mul(8, 16'h00E7, 16'h0019, 1'b1));
        end
    endtask

    task automatic test_wide16();
        logic [31:0] p; int lat;
        op16(16'h8000, 16'h7FFF, 1'b1, 1'b0, p, lat);
        checks++; if (p !== 32'hC0008000) begin failures++; $display("FAIL w16_prod got=%h exp=C0008000", p); end
        checks++; if (lat !== 16) begin failures++; $display("FAIL w16_latency got=%0d exp=16", lat); end
    endtask

    task automatic sweep8(input int n);
        logic [15:0] p; logic [31:0] e; int lat, bc;
        logic [7:0] x, y; bit m;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0: x = 8'h00; 1: x = 8'hFF; 2: x = 8'h80; 3: x = 8'h7F;
                default: x = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: y = 8'h00; 1: y = 8'hFF; 2: y = 8'h80; 3: y = 8'h7F;
                default: y = 8'($urandom);
            endcase
            m = 1'($urandom_range(0, 1));
            op8(x, y, m, (i > 0), 1'b0, p, lat, bc);
            e = ref_mul(8, {8'h00, x}, {8'h00, y}, m);
            checks++;
            if (p !== e[15:0]) begin
                failures++; $display("FAIL sweep8 x=%h y=%h m=%0d got=%h exp=%h", x, y, m, p, e[15:0]);
            end
            checks++;
            if (lat !== 8) begin
                failures++; $display("FAIL sweep8_latency got=%0d exp=8", lat);
            end
        end
    endtask

    task automatic sweep16(input int n);
        logic [31:0] p, e; int lat;
        logic [15:0] x, y; bit m;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0: x = 16'h0000; 1: x = 16'hFFFF; 2: x = 16'h8000; 3: x = 16'h7FFF;
                default: x = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0: y = 16'h0000; 1: y = 16'hFFFF; 2: y = 16'h8000; 3: y = 16'h7FFF;
                default: y = 16'($urandom);
            endcase
            m = 1'($urandom_range(0, 1));
            op16(x, y, m, (i > 0), p, lat);
            e = ref_mul(16, x, y, m);
            checks++;
            if (p !== e) begin
                failures++; $display("FAIL sweep16 x=%h y=%h m=%0d got=%h exp=%h", x, y, m, p, e);
            end
            checks++;
            if (lat !== 16) begin
                failures++; $display("FAIL sweep16_latency got=%0d exp=16", lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_wide16();
        fork
            sweep8(7000);
            sweep16(3500);
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
